// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and decode helpers for the data-memory responder
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  // Unknown load encodings fall back to a full-word load.
  function automatic mem_op_e decode_load(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return MEM_LB;
      3'b001:  return MEM_LH;
      3'b100:  return MEM_LBU;
      3'b101:  return MEM_LHU;
      default: return MEM_LW;
    endcase
  endfunction

  function automatic logic decode_store(input logic [2:0] funct3, output mem_op_e op);
    case (funct3)
      3'b000:  begin op = MEM_SB; return 1'b1; end
      3'b001:  begin op = MEM_SH; return 1'b1; end
      3'b010:  begin op = MEM_SW; return 1'b1; end
      default: begin op = MEM_SW; return 1'b0; end
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - misalign checks, store lane steering and load lane extraction
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data,
  output logic        ld_misalign,
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_bad
);

  mem_op_e     ld_op;
  mem_op_e     st_op;
  logic        st_ok;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_op       = decode_load(ld_funct3);
    ld_byte     = 8'(ld_word >> {ld_off, 3'b000});
    ld_half     = 16'(ld_word >> {ld_off[1], 4'b0000});
    ld_misalign = 1'b0;
    ld_data     = ld_word;
    case (ld_op)
      MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data = {24'h0, ld_byte};
      MEM_LH: begin
        ld_misalign = ld_off[0];
        ld_data     = {{16{ld_half[15]}}, ld_half};
      end
      MEM_LHU: begin
        ld_misalign = ld_off[0];
        ld_data     = {16'h0, ld_half};
      end
      default: ld_misalign = (ld_off != 2'b00);
    endcase
    if (ld_misalign) ld_data = '0;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_op    = MEM_SW;
    st_ok    = decode_store(st_funct3, st_op);
    st_bad   = !st_ok;
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_op)
      MEM_SB: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        st_bad   = !st_ok || st_off[0];
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: st_bad = !st_ok || (st_off != 2'b00);
    endcase
    if (st_bad) st_be = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port word RAM answering fixed-latency loads and LSQ store writebacks
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LOAD_LAT    = 2,
  parameter int PREG_W      = 7,
  parameter int ROB_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [31:0]       ld_req_addr,
  input  logic [2:0]        ld_req_funct3,
  input  logic [PREG_W-1:0] ld_req_pd,
  input  logic [ROB_W-1:0]  ld_req_rob,
  input  logic              st_req_valid,
  output logic              st_req_ready,
  input  logic [31:0]       st_req_addr,
  input  logic [31:0]       st_req_data,
  input  logic [2:0]        st_req_funct3,
  input  logic              flush,
  output logic              ld_resp_valid,
  output logic [31:0]       ld_resp_data,
  output logic [PREG_W-1:0] ld_resp_pd,
  output logic [ROB_W-1:0]  ld_resp_rob,
  output logic              ld_resp_err,
  output logic              st_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LOAD_LAT > 2) ? CW'(LOAD_LAT - 2) : '0;

  dmem_state_e       state;
  logic [CW-1:0]     cnt;
  logic [AW+1:0]     q_addr;
  logic [2:0]        q_funct3;
  logic [PREG_W-1:0] q_pd;
  logic [ROB_W-1:0]  q_rob;
  logic              resp_valid_q;

  logic              ld_fire;
  logic              st_fire;
  logic              read_cycle;
  logic [AW+1:0]     src_addr;
  logic [2:0]        src_funct3;
  logic [PREG_W-1:0] src_pd;
  logic [ROB_W-1:0]  src_rob;
  logic [31:0]       rd_word;
  logic [31:0]       al_ld_data;
  logic              al_ld_misalign;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              st_bad;
  logic              unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign ld_req_ready = (state == IDLE) && !flush;
  assign ld_fire      = ld_req_valid && ld_req_ready;
  assign read_cycle   = (state == WAIT) && (cnt == '0);
  assign st_req_ready = !read_cycle;
  assign st_fire      = st_req_valid && st_req_ready;
  assign st_err       = st_fire && st_bad;

  // A single-cycle latency reads on the accept edge, so it uses the live request fields.
  assign src_addr   = (LOAD_LAT == 1) ? ld_req_addr[AW+1:0] : q_addr;
  assign src_funct3 = (LOAD_LAT == 1) ? ld_req_funct3 : q_funct3;
  assign src_pd     = (LOAD_LAT == 1) ? ld_req_pd : q_pd;
  assign src_rob    = (LOAD_LAT == 1) ? ld_req_rob : q_rob;
  assign rd_word    = mem[src_addr[AW+1:2]];

  assign unused_addr_bits = ^{ld_req_addr[31:AW+2], st_req_addr[31:AW+2]};

  dmem_lane_align u_align (
    .ld_off      (src_addr[1:0]),
    .ld_funct3   (src_funct3),
    .ld_word     (rd_word),
    .ld_data     (al_ld_data),
    .ld_misalign (al_ld_misalign),
    .st_off      (st_req_addr[1:0]),
    .st_funct3   (st_req_funct3),
    .st_data     (st_req_data),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .st_bad      (st_bad)
  );

  always_ff @(posedge clk) begin
    if (st_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[st_req_addr[AW+1:2]][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      q_addr       <= '0;
      q_funct3     <= '0;
      q_pd         <= '0;
      q_rob        <= '0;
      resp_valid_q <= 1'b0;
      ld_resp_data <= '0;
      ld_resp_pd   <= '0;
      ld_resp_rob  <= '0;
      ld_resp_err  <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_fire) begin
            q_addr   <= ld_req_addr[AW+1:0];
            q_funct3 <= ld_req_funct3;
            q_pd     <= ld_req_pd;
            q_rob    <= ld_req_rob;
            if (LOAD_LAT == 1) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              ld_resp_data <= al_ld_data;
              ld_resp_err  <= al_ld_misalign;
              ld_resp_pd   <= src_pd;
              ld_resp_rob  <= src_rob;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            ld_resp_data <= al_ld_data;
            ld_resp_err  <= al_ld_misalign;
            ld_resp_pd   <= src_pd;
            ld_resp_rob  <= src_rob;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in the response cycle still suppresses the pulse.
  assign ld_resp_valid = resp_valid_q && !flush;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with a byte-array memory model
module tb_dmem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LOAD_LAT    = 2;
  localparam int PREG_W      = 7;
  localparam int ROB_W       = 5;

  logic              clk;
  logic              reset;
  logic              ld_req_valid;
  logic              ld_req_ready;
  logic [31:0]       ld_req_addr;
  logic [2:0]        ld_req_funct3;
  logic [PREG_W-1:0] ld_req_pd;
  logic [ROB_W-1:0]  ld_req_rob;
  logic              st_req_valid;
  logic              st_req_ready;
  logic [31:0]       st_req_addr;
  logic [31:0]       st_req_data;
  logic [2:0]        st_req_funct3;
  logic              flush;
  logic              ld_resp_valid;
  logic [31:0]       ld_resp_data;
  logic [PREG_W-1:0] ld_resp_pd;
  logic [ROB_W-1:0]  ld_resp_rob;
  logic              ld_resp_err;
  logic              st_err;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LOAD_LAT    (LOAD_LAT),
    .PREG_W      (PREG_W),
    .ROB_W       (ROB_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ld_req_valid  (ld_req_valid),
    .ld_req_ready  (ld_req_ready),
    .ld_req_addr   (ld_req_addr),
    .ld_req_funct3 (ld_req_funct3),
    .ld_req_pd     (ld_req_pd),
    .ld_req_rob    (ld_req_rob),
    .st_req_valid  (st_req_valid),
    .st_req_ready  (st_req_ready),
    .st_req_addr   (st_req_addr),
    .st_req_data   (st_req_data),
    .st_req_funct3 (st_req_funct3),
    .flush         (flush),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_data  (ld_resp_data),
    .ld_resp_pd    (ld_resp_pd),
    .ld_resp_rob   (ld_resp_rob),
    .ld_resp_err   (ld_resp_err),
    .st_err        (st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [6:0]  pd;
    logic [4:0]  rob;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [0:4095];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // Byte-addressed little-endian memory; only the low 12 address bits select a byte.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3,
                                             output logic err);
    int sz = op_size(f3);
    int base = int'(a[11:0]);
    logic [31:0] v = 32'h0;
    err = (int'(a[1:0]) % sz) != 0;
    if (err) return 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mdl[base + i]) << (8 * i));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic bit store_bad(input logic [31:0] a, input logic [2:0] f3);
    if (f3 > 3'd2) return 1'b1;
    return (int'(a[1:0]) % op_size(f3)) != 0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int base = int'(a[11:0]);
    for (int i = 0; i < op_size(f3); i++) mdl[base + i] = d[8*i +: 8];
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          output bit first_ready);
    bit bad;
    int n;
    @(negedge clk);
    st_req_valid = 1'b1;
    st_req_addr = a;
    st_req_data = d;
    st_req_funct3 = f3;
    #1;
    first_ready = st_req_ready;
    n = 0;
    while (!st_req_ready && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!st_req_ready) begin
      check("st_ready_timeout", 32'd0, 32'd1);
    end else begin
      bad = store_bad(a, f3);
      check("st_err", 32'(st_err), 32'(bad));
      @(posedge clk);
      if (!bad) model_write(a, d, f3);
    end
    #1;
    st_req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] pd,
                         input logic [4:0] rob, input bit push, input bit lit,
                         input logic [31:0] lit_data, input bit lit_err, input bit with_st,
                         input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf3);
    exp_t e;
    bit   sbad;
    logic merr;
    int   n;
    @(negedge clk);
    ld_req_valid = 1'b1;
    ld_req_addr = a;
    ld_req_funct3 = f3;
    ld_req_pd = pd;
    ld_req_rob = rob;
    if (with_st) begin
      st_req_valid = 1'b1;
      st_req_addr = sa;
      st_req_data = sd;
      st_req_funct3 = sf3;
    end
    #1;
    n = 0;
    while (!ld_req_ready && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ld_req_ready) begin
      check("ld_ready_timeout", 32'd0, 32'd1);
      ld_req_valid = 1'b0;
      st_req_valid = 1'b0;
      return;
    end
    sbad = 1'b1;
    if (with_st) begin
      sbad = store_bad(sa, sf3);
      check("st_ready_coincident", 32'(st_req_ready), 32'd1);
      check("st_err_coincident", 32'(st_err), 32'(sbad));
    end
    e.cyc = cyc + LOAD_LAT;
    @(posedge clk);
    if (with_st && !sbad) model_write(sa, sd, sf3);
    if (lit) begin
      e.data = lit_data;
      e.err = lit_err;
    end else begin
      e.data = model_load(a, f3, merr);
      e.err = merr;
    end
    e.pd = pd;
    e.rob = rob;
    if (push) exp_q.push_back(e);
    #1;
    ld_req_valid = 1'b0;
    st_req_valid = 1'b0;
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #3;
    if (!reset && ld_resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", ld_resp_data, e.data);
        check("resp_pd", 32'(ld_resp_pd), 32'(e.pd));
        check("resp_rob", 32'(ld_resp_rob), 32'(e.rob));
        check("resp_err", 32'(ld_resp_err), 32'(e.err));
        check("resp_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    bit          fr;
    logic [31:0] a;
    logic [31:0] sa;
    int          n;
    reset = 1'b1;
    flush = 1'b0;
    ld_req_valid = 1'b0;
    ld_req_addr = '0;
    ld_req_funct3 = '0;
    ld_req_pd = '0;
    ld_req_rob = '0;
    st_req_valid = 1'b0;
    st_req_addr = '0;
    st_req_data = '0;
    st_req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
    check("rst_resp_data", ld_resp_data, 32'd0);
    check("rst_resp_pd", 32'(ld_resp_pd), 32'd0);
    check("rst_resp_rob", 32'(ld_resp_rob), 32'd0);
    check("rst_resp_err", 32'(ld_resp_err), 32'd0);
    check("rst_st_err", 32'(st_err), 32'd0);
    check("rst_ld_ready", 32'(ld_req_ready), 32'd1);
    check("rst_st_ready", 32'(st_req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int w = 0; w < 64; w++) do_store(32'(w * 4), 32'h0, 3'b010, fr);

    do_store(32'h40, 32'hDEADBEEF, 3'b010, fr);
    do_load(32'h40, 3'b010, 7'd5, 5'd3, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("ready_in_wait", 32'(ld_req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_in_resp", 32'(ld_req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_back_idle", 32'(ld_req_ready), 32'd1);

    do_store(32'h40, 32'h0, 3'b010, fr);
    do_store(32'h41, 32'h80, 3'b000, fr);
    do_load(32'h41, 3'b000, 7'd1, 5'd1, 1, 1, 32'hFFFFFF80, 0, 0, 0, 0, 0);
    do_load(32'h41, 3'b100, 7'd2, 5'd2, 1, 1, 32'h00000080, 0, 0, 0, 0, 0);
    do_load(32'h42, 3'b001, 7'd3, 5'd3, 1, 1, 32'h00000000, 0, 0, 0, 0, 0);
    do_load(32'h40, 3'b101, 7'd4, 5'd4, 1, 1, 32'h00008000, 0, 0, 0, 0, 0);

    do_load(32'h40, 3'b010, 7'd9, 5'd1, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("ready_during_flush", 32'(ld_req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_load(32'h40, 3'b010, 7'd10, 5'd2, 1, 1, 32'h00008000, 0, 0, 0, 0, 0);

    do_load(32'h44, 3'b010, 7'd11, 5'd6, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;

    do_load(32'h80, 3'b010, 7'd20, 5'd4, 1, 1, 32'h12345678, 0, 1, 32'h80, 32'h12345678, 3'b010);
    do_load(32'h80, 3'b010, 7'd21, 5'd5, 1, 1, 32'h12345678, 0, 0, 0, 0, 0);
    do_store(32'h80, 32'hCAFEF00D, 3'b010, fr);
    check("st_ready_read_cycle", 32'(fr), 32'd0);
    do_load(32'h80, 3'b010, 7'd22, 5'd6, 1, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0);

    do_load(32'h42, 3'b010, 7'd23, 5'd7, 1, 1, 32'h0, 1, 0, 0, 0, 0);
    do_store(32'h43, 32'h0000BEEF, 3'b001, fr);
    do_load(32'h40, 3'b010, 7'd24, 5'd8, 1, 1, 32'h00008000, 0, 0, 0, 0, 0);

    do_load(32'h40, 3'b010, 7'd30, 5'd9, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_wait_valid", 32'(ld_resp_valid), 32'd0);
    check("rst_wait_data", ld_resp_data, 32'd0);
    check("rst_wait_pd", 32'(ld_resp_pd), 32'd0);
    check("rst_wait_rob", 32'(ld_resp_rob), 32'd0);
    check("rst_wait_err", 32'(ld_resp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(ld_req_ready), 32'd1);
    repeat (4) @(posedge clk);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      a[11:8] = 4'h0;
      sa = $urandom;
      sa[11:8] = 4'h0;
      case ($urandom_range(0, 2))
        0: do_store(a, $urandom, 3'($urandom_range(0, 7)), fr);
        1: do_load(a, 3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 1, 0, 0, 0,
                   0, 0, 0, 0);
        default: do_load(a, 3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 1, 0, 0, 0,
                         1, sa, $urandom, 3'($urandom_range(0, 7)));
      endcase
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
